// File: rtl/rr_enc_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
package rr_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of an index able to address n lines; at least one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_encoder_prio_scan.sv
// prio_scan: combinational highest-set-bit finder over an N-bit vector.
module prio_scan
    import rr_enc_pkg::*;
#(
    parameter int N = 16,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Ascending scan; the last set bit seen is the highest one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered N:log2(N) priority encoder with a
// one-deep valid/ready result register. MODE selects fixed priority
// (highest index wins) or round-robin.
// Optional one-hot grant output: define RR_PRIORITY_ENCODER_ONEHOT_EN.
module rr_priority_encoder
    import rr_enc_pkg::*;
#(
    parameter int N    = 16,
    parameter int W    = idx_width(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
    ,
    output logic [N-1:0] grant
`endif
);

    logic         any_req;
    logic [W-1:0] winner;
    logic         slot_open;
    logic         capture;

    assign slot_open = !out_valid || out_ready;
    assign capture   = slot_open && enable && any_req;

    if (MODE == MODE_RR) begin : g_rr
        logic [W-1:0] ptr;
        logic [N-1:0] cand;
        logic         cand_found;
        logic [W-1:0] cand_idx;
        logic [W-1:0] raw_idx;

        // Candidate set: requests at or below the pointer.
        always_comb begin
            cand = '0;
            for (int i = 0; i < N; i++) begin
                cand[i] = req[i] && (W'(i) <= ptr);
            end
        end

        prio_scan #(.N(N), .W(W)) u_cand (
            .vec   (cand),
            .found (cand_found),
            .idx   (cand_idx)
        );

        prio_scan #(.N(N), .W(W)) u_raw (
            .vec   (req),
            .found (any_req),
            .idx   (raw_idx)
        );

        // Empty candidate set wraps around to the highest raw request.
        assign winner = cand_found ? cand_idx : raw_idx;

        // Pointer moves just below the winner on every capture; winner 0 wraps to N-1.
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr <= W'(N - 1);
            end else if (capture) begin
                ptr <= (winner == '0) ? W'(N - 1) : winner - W'(1);
            end
        end
    end else begin : g_fixed
        prio_scan #(.N(N), .W(W)) u_scan (
            .vec   (req),
            .found (any_req),
            .idx   (winner)
        );
    end

    // Result register: load on capture, drop valid when the open slot stays empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (slot_open) begin
            out_valid <= capture;
            if (capture) begin
                out <= winner;
            end
        end
    end

`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
    // One-hot mirror of out, zero whenever the result is not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
        end else if (slot_open) begin
            grant <= capture ? (N'(1) << winner) : '0;
        end
    end
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder: three instances (N=16 fixed, N=16 RR,
// N=5 RR) driven together, compared every cycle against a behavioural model.
module tb_rr_priority_encoder;

    logic        clk = 1'b0;
    logic        rst, enable, out_ready;
    logic [15:0] req16;
    logic [4:0]  req5;
    logic        v0, v1, v2;
    logic [3:0]  o0, o1;
    logic [2:0]  o2;
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
    logic [15:0] g0, g1;
    logic [4:0]  g2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance
    int m_valid [3];
    int m_out   [3];
    int m_ptr   [3];
    int m_n     [3] = '{16, 16, 5};
    int m_mode  [3] = '{0, 1, 1};

    always #5 clk = ~clk;

    rr_priority_encoder #(.N(16), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .req(req16), .out_ready(out_ready),
        .out_valid(v0), .out(o0)
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
        , .grant(g0)
`endif
    );

    rr_priority_encoder #(.N(16), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .req(req16), .out_ready(out_ready),
        .out_valid(v1), .out(o1)
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
        , .grant(g1)
`endif
    );

    rr_priority_encoder #(.N(5), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .req(req5), .out_ready(out_ready),
        .out_valid(v2), .out(o2)
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
        , .grant(g2)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner selection straight from the rules: RR prefers the highest
    // request at or below the pointer, otherwise the highest request overall.
    function automatic int pick(input int r, input int n, input int mode, input int p);
        int w = -1;
        if (mode == 1) begin
            for (int i = 0; i < n; i++)
                if (r[i] && i <= p) w = i;
        end
        if (w < 0) begin
            for (int i = 0; i < n; i++)
                if (r[i]) w = i;
        end
        return w;
    endfunction

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            int r;
            r = (d == 2) ? int'(req5) : int'(req16);
            if (rst) begin
                m_valid[d] = 0;
                m_out[d]   = 0;
                m_ptr[d]   = m_n[d] - 1;
            end else if (m_valid[d] == 0 || out_ready) begin
                if (enable && r != 0) begin
                    int w;
                    w = pick(r, m_n[d], m_mode[d], m_ptr[d]);
                    m_out[d]   = w;
                    m_valid[d] = 1;
                    m_ptr[d]   = (w == 0) ? m_n[d] - 1 : w - 1;
                end else begin
                    m_valid[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("valid0", int'(v0), m_valid[0]);
        chk("out0",   int'(o0), m_out[0]);
        chk("valid1", int'(v1), m_valid[1]);
        chk("out1",   int'(o1), m_out[1]);
        chk("valid2", int'(v2), m_valid[2]);
        chk("out2",   int'(o2), m_out[2]);
        chk("out2_range", int'(o2 < 3'd5), 1);
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
        chk("grant0", int'(g0), m_valid[0] ? (1 << m_out[0]) : 0);
        chk("grant1", int'(g1), m_valid[1] ? (1 << m_out[1]) : 0);
        chk("grant2", int'(g2), m_valid[2] ? (1 << m_out[2]) : 0);
`endif
    endtask

    task automatic step(input logic rs, input logic en, input logic rdy,
                        input logic [15:0] r16, input logic [4:0] r5);
        @(negedge clk);
        rst       = rs;
        enable    = en;
        out_ready = rdy;
        req16     = r16;
        req5      = r5;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    int exp_rr16 [6] = '{15, 8, 0, 15, 8, 0};
    int exp_rr5  [5] = '{4, 0, 4, 0, 4};

    initial begin
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0; req16 = '0; req5 = '0;
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_out[d] = 0; m_ptr[d] = m_n[d] - 1;
        end

        // Reset then idle
        step(1, 0, 1, 16'h0000, 5'b00000);
        step(1, 0, 1, 16'h0000, 5'b00000);
        chk("rst_valid", int'(v0), 0);
        chk("rst_out",   int'(o0), 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 16'h0000, 5'b00000);
            chk("idle_valid", int'(v0), 0);
        end

        // Fixed priority
        step(0, 1, 1, 16'h8041, 5'b10001);
        chk("fixed_8041", int'(o0), 15);
        chk("fixed_valid", int'(v0), 1);
        step(0, 1, 1, 16'h0018, 5'b00110);
        chk("fixed_0018", int'(o0), 4);

        // Stall: result held while consumer is not ready
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 16'h0001, 5'b00001);
            chk("stall_out", int'(o0), 4);
            chk("stall_valid", int'(v0), 1);
        end
        step(0, 1, 1, 16'h0001, 5'b00001);
        chk("release_out", int'(o0), 0);

        // Round-robin fairness from a fresh pointer
        step(1, 0, 1, 16'h0000, 5'b00000);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 1, 16'h8101, 5'b10001);
            chk("rr16_seq", int'(o1), exp_rr16[k]);
            chk("rr5_seq",  int'(o2), exp_rr5[k]);
        end

        // Enable low: pending result held, then drained; pointer unchanged
        step(0, 0, 0, 16'h0002, 5'b00010);
        chk("en_hold", int'(v1), 1);
        step(0, 0, 1, 16'h0002, 5'b00010);
        chk("en_drop", int'(v1), 0);
        step(0, 1, 1, 16'h8101, 5'b10001);
        chk("ptr_kept", int'(o1), 0);

        // Reset with a valid result pending
        step(1, 1, 0, 16'h8101, 5'b10001);
        chk("rst_mid_valid", int'(v1), 0);
        step(0, 1, 1, 16'h0106, 5'b00110);
        chk("rst_mid_rr", int'(o1), 8);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic rs_r, en_r, rdy_r;
            rs_r  = ($urandom_range(0, 99) < 3);
            en_r  = ($urandom_range(0, 99) < 80);
            rdy_r = ($urandom_range(0, 99) < 70);
            step(rs_r, en_r, rdy_r, 16'($urandom_range(0, 65535)),
                 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised, registered N:log2(N) priority encoder. It selects one active request line and reports the winning index, either by fixed priority or by round-robin. The output is a one-deep result register with a valid/ready handshake, so the block can sit between request sources and a pipelined consumer such as an interrupt controller or bus arbiter. It supersedes the fixed-width combinational encoders for all new designs.

## Interface
Parameters:
- N, 16: number of request lines; legal range 2..256; need not be a power of two.
- W, $clog2(N): index width; derived, never overridden.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  input  1  Sole clock; all state changes on its rising edge.
- rst  input  1  Reset, synchronous and active-high.
- enable  input  1  Capture enable; when low, no new result is captured.
- req  input  N  Request lines; bit i asserts request i.
- out_valid  output  1  Result register holds a valid index.
- out  output  W  Winning index, 0-based.
- out_ready  input  1  Consumer accepts the result this cycle.
- grant  output  N  One-hot form of out; only present when RR_PRIORITY_ENCODER_ONEHOT_EN is defined.

Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- Capture slot is open when out_valid==0, or when out_valid && out_ready.
- Capture fires when the slot is open, enable==1 and |req==1. On capture:
  - out is loaded with the winner.
  - out_valid is set to 1.
- Slot open and no capture (enable==0 or req==0): out_valid clears to 0. out holds its last value.
- Slot closed (out_valid && !out_ready): out, out_valid and grant hold stable. req is ignored.
- MODE 0: winner = highest set index of req.
- MODE 1: the block keeps a pointer ptr (W bits).
  - Candidate set = req bits at index <= ptr.
  - If the candidate set is non-empty, winner = its highest set bit. Otherwise winner = highest set bit of req (wrap-around).
  - On each capture, ptr = winner-1. Winner 0 wraps ptr to N-1.
  - ptr never changes without a capture.
- Width rule: out and ptr are W bits. Values >= N are never produced.

## Timing
- Latency: req sampled at edge k appears on out/out_valid after edge k.
- Back-to-back throughput: one result per cycle while out_ready==1.
- Simultaneous drain and capture in the same cycle: the new result replaces the old one. out_valid stays 1.
- Reset values:
  - out_valid=0, out=0, grant=0.
  - ptr=N-1, so the first round-robin grant matches fixed priority.
- Reset mid-operation: a pending unaccepted result is discarded. ptr returns to N-1.
- rst has priority over all other inputs.
- The block does not inspect req changes while the slot is closed.

## Configuration
- RR_PRIORITY_ENCODER_ONEHOT_EN defined:
  - grant port exists. grant = 1<<out when out_valid, else 0.
  - grant is registered alongside out, with identical timing and reset.
- Not defined: grant port and its register are absent. All other behaviour is identical.

## Structure
- Shared package rr_enc_pkg holds:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - Index-width helper function used to derive W.
- Sub-module prio_scan: combinational, parametrised by N. Input is an N-bit vector; outputs are found plus the highest set index.
  - MODE 0 instantiates prio_scan once.
  - MODE 1 instantiates it twice: one on the masked candidate set, one on raw req.
- Top level owns the result register, handshake logic and ptr.

## Test plan
- Reset then idle, N=16, MODE 0: rst high 2 cycles, req=0 -> out_valid=0, out=0 throughout.
- Fixed priority, MODE 0: req=16'h8041, out_ready=1 -> next cycle out=15, out_valid=1. Then req=16'h0018 -> out=4.
- Stall: out_valid=1 with out=4 and out_ready=0 for 3 cycles while req changes to 16'h0001 -> out stays 4. Release out_ready -> out=0 one cycle later.
- Round-robin fairness, MODE 1: req=16'h8101 held, out_ready=1 -> outs 15, 8, 0, 15, 8, 0... Assert ptr wrap from winner 0 to 15.
- Non-power-of-two, N=5, MODE 1: req=5'b10001 -> outs 4, 0, 4. out never >= 5.
- Enable and reset mid-operation: enable=0 with req=16'h0002 -> out_valid drops after the pending result is taken, and ptr is unchanged. rst while out_valid=1 -> out_valid=0 next edge, and the next RR grant is the highest set bit. With RR_PRIORITY_ENCODER_ONEHOT_EN defined, check grant==1<<out on every valid cycle.
